// File: rtl/adpll_lock_monitor.sv
// Lock monitor for the ring ADPLL: measures gen_div8 against ref over fixed windows,
// tracks peak phase error, and runs a hysteretic lock FSM.
module adpll_lock_monitor #(
  parameter int unsigned PDET_WIDTH     = 5,
  parameter int unsigned DCO_CC_WIDTH   = 5,
  parameter int unsigned CNT_WIDTH      = 8,
  parameter int unsigned WINDOW         = 64,
  parameter int unsigned FREQ_TOL       = 1,
  parameter int unsigned ERR_TOL        = 3,
  parameter int unsigned LOCK_WINDOWS   = 4,
  parameter int unsigned UNLOCK_WINDOWS = 2,
  parameter int unsigned TIMEOUT        = 4096
) (
  input  logic                    fpga_clk_i,
  input  logic                    reset_i,
  input  logic                    ref_clk_i,
  input  logic                    gen_div8_i,
  input  logic [PDET_WIDTH-1:0]   error_i,
  input  logic [DCO_CC_WIDTH-1:0] dco_cc_i,
  input  logic                    clear_i,
  output logic                    lock_o,
  output logic [1:0]              state_o,
  output logic                    window_valid_o,
  output logic [CNT_WIDTH:0]      freq_diff_o,
  output logic [PDET_WIDTH-1:0]   err_peak_o,
  output logic [DCO_CC_WIDTH-1:0] dco_cc_snap_o,
  output logic                    lost_lock_o
);

  localparam int unsigned CntW = CNT_WIDTH;
  localparam int unsigned FdW  = CNT_WIDTH + 1;
  localparam int unsigned MagW = PDET_WIDTH - 1;
  localparam int unsigned IdW  = $clog2(TIMEOUT + 1);
  localparam int unsigned GcW  = $clog2(LOCK_WINDOWS + 1);
  localparam int unsigned BcW  = $clog2(UNLOCK_WINDOWS + 1);

  localparam logic [1:0] StUnlocked  = 2'd0;
  localparam logic [1:0] StAcquiring = 2'd1;
  localparam logic [1:0] StLocked    = 2'd2;

  logic [2:0]              r_ref_sync;
  logic [2:0]              r_gen_sync;
  logic [CntW-1:0]         r_ref_cnt;
  logic [CntW-1:0]         r_gen_cnt;
  logic [MagW-1:0]         r_peak;
  logic [IdW-1:0]          r_idle_cnt;
  logic [1:0]              r_state;
  logic [GcW-1:0]          r_good_cnt;
  logic [BcW-1:0]          r_bad_cnt;
  logic                    r_lock;
  logic                    r_valid;
  logic [FdW-1:0]          r_fd;
  logic [MagW-1:0]         r_peak_pub;
  logic [DCO_CC_WIDTH-1:0] r_snap;
  logic                    r_lost;

  logic            w_ref_stb;
  logic            w_gen_stb;
  logic [CntW-1:0] w_gen_total;
  logic [FdW-1:0]  w_fd_calc;
  logic [FdW-1:0]  w_fd_abs;
  logic [FdW-1:0]  w_fd_next;
  logic [MagW-1:0] w_err_mag;
  logic [MagW-1:0] w_peak_next;
  logic            w_close;
  logic            w_timeout;
  logic            w_pub;
  logic            w_good;
  logic [1:0]      w_state_d;
  logic [GcW-1:0]  w_good_d;
  logic [BcW-1:0]  w_bad_d;
  logic            w_set_lost;

  // Third flop of each chain is the edge-detect history.
  assign w_ref_stb = r_ref_sync[1] & ~r_ref_sync[2];
  assign w_gen_stb = r_gen_sync[1] & ~r_gen_sync[2];

  assign w_gen_total = (w_gen_stb && (r_gen_cnt != {CntW{1'b1}})) ? r_gen_cnt + CntW'(1)
                                                                    : r_gen_cnt;
  assign w_fd_calc   = {1'b0, w_gen_total} - FdW'(WINDOW);
  assign w_fd_abs    = w_fd_calc[FdW-1] ? (FdW'(0) - w_fd_calc) : w_fd_calc;

  // Most-negative error has no positive twin, so its magnitude saturates.
  always_comb begin
    w_err_mag = error_i[MagW-1:0];
    if (error_i[PDET_WIDTH-1]) begin
      if (error_i[MagW-1:0] == {MagW{1'b0}}) w_err_mag = {MagW{1'b1}};
      else                                   w_err_mag = MagW'(0) - error_i[MagW-1:0];
    end
  end

  assign w_peak_next = (w_err_mag > r_peak) ? w_err_mag : r_peak;

  assign w_close   = w_ref_stb && (r_ref_cnt == CntW'(WINDOW - 1));
  assign w_timeout = !w_ref_stb && (r_idle_cnt == IdW'(TIMEOUT - 1));
  assign w_pub     = w_close | w_timeout;
  assign w_fd_next = w_timeout ? {1'b0, {CntW{1'b1}}} : w_fd_calc;
  assign w_good    = !w_timeout && (w_fd_abs <= FdW'(FREQ_TOL)) &&
                     (w_peak_next <= MagW'(ERR_TOL));

  always_comb begin
    w_state_d  = r_state;
    w_good_d   = r_good_cnt;
    w_bad_d    = r_bad_cnt;
    w_set_lost = 1'b0;
    if (w_pub) begin
      case (r_state)
        StUnlocked: begin
          if (w_good) begin
            w_good_d  = GcW'(1);
            w_bad_d   = '0;
            w_state_d = (LOCK_WINDOWS <= 1) ? StLocked : StAcquiring;
          end
        end
        StAcquiring: begin
          if (w_good) begin
            w_good_d = r_good_cnt + GcW'(1);
            if (w_good_d >= GcW'(LOCK_WINDOWS)) begin
              w_state_d = StLocked;
              w_bad_d   = '0;
            end
          end else begin
            w_state_d = StUnlocked;
            w_good_d  = '0;
          end
        end
        StLocked: begin
          if (w_good) begin
            w_bad_d = '0;
          end else begin
            w_bad_d = r_bad_cnt + BcW'(1);
            if (w_bad_d >= BcW'(UNLOCK_WINDOWS)) begin
              w_state_d  = StUnlocked;
              w_good_d   = '0;
              w_bad_d    = '0;
              w_set_lost = 1'b1;
            end
          end
        end
        default: begin
          w_state_d = StUnlocked;
          w_good_d  = '0;
          w_bad_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge fpga_clk_i) begin
    if (!reset_i) begin
      r_ref_sync <= '0;
      r_gen_sync <= '0;
      r_ref_cnt  <= '0;
      r_gen_cnt  <= '0;
      r_peak     <= '0;
      r_idle_cnt <= '0;
      r_state    <= StUnlocked;
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
      r_lock     <= 1'b0;
      r_valid    <= 1'b0;
      r_fd       <= '0;
      r_peak_pub <= '0;
      r_snap     <= '0;
      r_lost     <= 1'b0;
    end else begin
      r_ref_sync <= {r_ref_sync[1:0], ref_clk_i};
      r_gen_sync <= {r_gen_sync[1:0], gen_div8_i};
      r_valid    <= w_pub;
      if (w_pub) begin
        // Closing-cycle gen strobe is already folded into w_gen_total.
        r_ref_cnt  <= '0;
        r_gen_cnt  <= '0;
        r_peak     <= '0;
        r_idle_cnt <= '0;
        r_fd       <= w_fd_next;
        r_peak_pub <= w_peak_next;
        r_snap     <= dco_cc_i;
      end else begin
        r_ref_cnt  <= r_ref_cnt + CntW'(w_ref_stb);
        r_gen_cnt  <= w_gen_total;
        r_peak     <= w_peak_next;
        r_idle_cnt <= w_ref_stb ? '0 : r_idle_cnt + IdW'(1);
      end
      r_state    <= w_state_d;
      r_good_cnt <= w_good_d;
      r_bad_cnt  <= w_bad_d;
      r_lock     <= (w_state_d == StLocked);
      if (w_set_lost)   r_lost <= 1'b1;
      else if (clear_i) r_lost <= 1'b0;
    end
  end

  assign lock_o         = r_lock;
  assign state_o        = r_state;
  assign window_valid_o = r_valid;
  assign freq_diff_o    = r_fd;
  assign err_peak_o     = {1'b0, r_peak_pub};
  assign dco_cc_snap_o  = r_snap;
  assign lost_lock_o    = r_lost;

endmodule

// File: tb/tb_adpll_lock_monitor.sv
// Directed bench for adpll_lock_monitor: ref and gen are built as 8-cycle periods,
// 64 periods per measurement window.
module tb_adpll_lock_monitor;

  logic       clk;
  logic       reset_i;
  logic       ref_clk_i;
  logic       gen_div8_i;
  logic [4:0] error_i;
  logic [4:0] dco_cc_i;
  logic       clear_i;
  logic       lock_o;
  logic [1:0] state_o;
  logic       window_valid_o;
  logic [8:0] freq_diff_o;
  logic [4:0] err_peak_o;
  logic [4:0] dco_cc_snap_o;
  logic       lost_lock_o;

  int         n_chk;
  int         n_pass;
  int         v_cnt;
  int         v_per;
  logic [8:0] v_fd;
  logic [4:0] v_peak;
  logic [4:0] v_snap;

  adpll_lock_monitor dut (
    .fpga_clk_i     (clk),
    .reset_i        (reset_i),
    .ref_clk_i      (ref_clk_i),
    .gen_div8_i     (gen_div8_i),
    .error_i        (error_i),
    .dco_cc_i       (dco_cc_i),
    .clear_i        (clear_i),
    .lock_o         (lock_o),
    .state_o        (state_o),
    .window_valid_o (window_valid_o),
    .freq_diff_o    (freq_diff_o),
    .err_peak_o     (err_peak_o),
    .dco_cc_snap_o  (dco_cc_snap_o),
    .lost_lock_o    (lost_lock_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // gen pulses at offsets 0-1 (before ref at 2-5); extra gen pulse at 4-5 in the
  // first n_extra periods. error_i is driven to err_val only in periods 10..19.
  task automatic emit(input int n_per, input int n_extra, input int err_val,
                      input int dco_val, input bit clr_hold);
    v_cnt    = 0;
    v_per    = -1;
    dco_cc_i = 5'(dco_val);
    clear_i  = clr_hold;
    for (int p = 0; p < n_per; p++) begin
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (window_valid_o) begin
          v_cnt++;
          v_per   = p;
          v_fd    = freq_diff_o;
          v_peak  = err_peak_o;
          v_snap  = dco_cc_snap_o;
          clear_i = 1'b0;
        end
        ref_clk_i  = (c >= 2 && c <= 5);
        gen_div8_i = (c <= 1) || (p < n_extra && (c == 4 || c == 5));
        error_i    = (p >= 10 && p < 20) ? 5'(err_val) : 5'd0;
      end
    end
  endtask

  task automatic win(input string tag, input int n_extra, input int err_val, input int dco_val,
                     input bit clr, input int exp_fd, input int exp_peak, input int exp_state);
    emit(64, n_extra, err_val, dco_val, clr);
    check({tag, "_nvalid"}, v_cnt, 1);
    check({tag, "_fd"}, {23'b0, v_fd}, exp_fd);
    check({tag, "_peak"}, {27'b0, v_peak}, exp_peak);
    check({tag, "_state"}, {30'b0, state_o}, exp_state);
  endtask

  initial begin
    int  n;
    bit  seen;
    n_chk      = 0;
    n_pass     = 0;
    reset_i    = 1'b0;
    ref_clk_i  = 1'b0;
    gen_div8_i = 1'b0;
    error_i    = '0;
    dco_cc_i   = '0;
    clear_i    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_lock", {31'b0, lock_o}, 0);
    check("rst_state", {30'b0, state_o}, 0);
    check("rst_valid", {31'b0, window_valid_o}, 0);
    check("rst_lost", {31'b0, lost_lock_o}, 0);
    reset_i = 1'b1;

    // Acquire lock from matched frequencies
    win("g1", 0, 0, 0, 0, 0, 0, 1);
    win("g2", 0, 0, 0, 0, 0, 0, 1);
    win("g3", 0, 0, 0, 0, 0, 0, 1);
    check("g3_lock", {31'b0, lock_o}, 0);
    win("g4", 0, 0, 0, 0, 0, 0, 2);
    check("g4_lock", {31'b0, lock_o}, 1);

    // Bad, good, bad keeps lock; second consecutive bad drops it
    win("b1", 0, -5, 0, 0, 0, 5, 2);
    check("b1_lock", {31'b0, lock_o}, 1);
    win("gm", 0, 0, 0, 0, 0, 0, 2);
    win("b2", 0, -5, 0, 0, 0, 5, 2);
    check("b2_lock", {31'b0, lock_o}, 1);
    win("b3", 0, -5, 0, 0, 0, 5, 0);
    check("b3_lock", {31'b0, lock_o}, 0);
    check("b3_lost", {31'b0, lost_lock_o}, 1);
    @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    check("clr_lost", {31'b0, lost_lock_o}, 0);

    // Three good (one at +1), then +2 from ACQUIRING with good_cnt=3
    win("a1", 0, 0, 0, 0, 0, 0, 1);
    win("a2", 1, 0, 0, 0, 1, 0, 1);
    win("a3", 0, 0, 0, 0, 0, 0, 1);
    win("f2", 2, 0, 0, 0, 2, 0, 0);
    check("f2_lock", {31'b0, lock_o}, 0);

    // Most-negative error saturates; DCO snapshot
    win("sat", 0, -16, -3, 0, 0, 15, 0);
    check("sat_snap", {27'b0, v_snap}, 5'b11101);

    // Timeout: ref held low
    win("t0", 0, 0, 0, 0, 0, 0, 1);
    ref_clk_i  = 1'b0;
    gen_div8_i = 1'b0;
    dco_cc_i   = 5'd7;
    n          = 0;
    seen       = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (window_valid_o) begin
        seen   = 1'b1;
        v_fd   = freq_diff_o;
        v_snap = dco_cc_snap_o;
      end
    end
    check("to_seen", {31'b0, seen}, 1);
    check("to_fd", {23'b0, v_fd}, 255);
    check("to_when", {31'b0, (n >= 4090 && n <= 4100)}, 1);
    check("to_snap", {27'b0, v_snap}, 7);
    @(negedge clk);
    check("to_state", {30'b0, state_o}, 0);

    // Relock, then set and clear of lost_lock on the same cycle
    win("r1", 0, 0, 0, 0, 0, 0, 1);
    win("r2", 0, 0, 0, 0, 0, 0, 1);
    win("r3", 0, 0, 0, 0, 0, 0, 1);
    win("r4", 0, 0, 0, 0, 0, 0, 2);
    win("r5", 0, -5, 0, 0, 0, 5, 2);
    win("r6", 0, -5, 0, 1, 0, 5, 0);
    check("sc_lost", {31'b0, lost_lock_o}, 1);

    // Relock, then reset mid-window
    win("m1", 0, 0, 0, 0, 0, 0, 1);
    win("m2", 0, 0, 0, 0, 0, 0, 1);
    win("m3", 0, 0, 0, 0, 0, 0, 1);
    win("m4", 0, -2, 9, 0, 0, 2, 2);
    check("m4_snap", {27'b0, v_snap}, 9);
    emit(30, 0, 0, 0, 0);
    check("pre_nvalid", v_cnt, 0);
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    check("mr_lock", {31'b0, lock_o}, 0);
    check("mr_state", {30'b0, state_o}, 0);
    check("mr_valid", {31'b0, window_valid_o}, 0);
    check("mr_fd", {23'b0, freq_diff_o}, 0);
    check("mr_peak", {27'b0, err_peak_o}, 0);
    check("mr_snap", {27'b0, dco_cc_snap_o}, 0);
    check("mr_lost", {31'b0, lost_lock_o}, 0);
    reset_i = 1'b1;
    emit(64, 0, 0, 0, 0);
    check("post_nvalid", v_cnt, 1);
    check("post_period", v_per, 63);
    check("post_fd", {23'b0, v_fd}, 0);
    check("post_state", {30'b0, state_o}, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
